// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM region arbiter.
// Optional build macro SDRAM_ARB_RR_EN (used by sdram_arb_pick) selects round-robin service.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StAck
   } arb_state_t;

   // Width of the WAIT-state timeout counter.
   localparam int unsigned TO_W = 8;

   // Region base plus local address masked to a 2^log2 byte window.
   // The sum is returned at 32 bits; callers truncate to their address width,
   // which gives the intended silent wrap.
   function automatic logic [31:0] region_addr(input logic [31:0] base,
                                                input logic [31:0] addr,
                                                input logic [4:0]  log2);
      logic [31:0] mask;
      mask = (32'd1 << log2) - 32'd1;
      return base + (addr & mask);
   endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selector for channels 1..NUM_CH-1 (channel 0 is handled by the top).
// Build macro SDRAM_ARB_RR_EN: defined -> round-robin starting at ptr, undefined -> lowest index.
module sdram_arb_pick #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned GW     = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [GW-1:0]     ptr,
   output logic [GW-1:0]     idx,
   output logic              valid
);

   // Channel 0 never competes here.
   logic unused_req0;
   assign unused_req0 = req[0];

`ifdef SDRAM_ARB_RR_EN
   // k-th candidate in round-robin order starting at ptr, wrapping N-1 -> 1.
   function automatic int unsigned rr_ch(input logic [GW-1:0] p, input int unsigned k);
      return 1 + ((32'(p) + k - 1) % (NUM_CH - 1));
   endfunction

   // First requesting channel at or after the pointer.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
         if (!valid && req[rr_ch(ptr, k)]) begin
            idx   = GW'(rr_ch(ptr, k));
            valid = 1'b1;
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Lowest requesting index wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned k = 1; k < NUM_CH; k++) begin
         if (!valid && req[k]) begin
            idx   = GW'(k);
            valid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/sdram_region_arbiter.sv
// N-channel front end for the 8-bit SDRAM controller port: per-channel address regions,
// registered request/ack handshake and a completion timeout.
// Build macro SDRAM_ARB_RR_EN: round-robin among channels 1..N-1 (default fixed priority).
module sdram_region_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned              NUM_CH       = 4,
   parameter int unsigned              ADDR_W       = 23,
   parameter int unsigned              CH_AW        = 16,
   parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE      = {23'h10000, 23'h04000, 23'h00000, 23'h00000},
   parameter logic [NUM_CH*5-1:0]      CH_SIZE_LOG2 = {5'd16, 5'd14, 5'd14, 5'd15},
   parameter int unsigned              TIMEOUT      = 255
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            ch_req,
   input  logic [NUM_CH-1:0]            ch_we,
   input  logic [NUM_CH*CH_AW-1:0]      ch_addr,
   input  logic [NUM_CH*8-1:0]          ch_din,
   output logic [NUM_CH*8-1:0]          ch_dout,
   output logic [NUM_CH-1:0]            ch_ack,
   output logic [ADDR_W-1:0]            sdram_addr,
   output logic [7:0]                   sdram_din,
   output logic                         sdram_rd,
   output logic                         sdram_we,
   input  logic [7:0]                   sdram_dout,
   input  logic                         sdram_ready,
   output logic                         busy,
   output logic [$clog2(NUM_CH)-1:0]    grant,
   output logic                         timeout_err
);

   localparam int unsigned GW = $clog2(NUM_CH);

   arb_state_t        state;
   logic              we_q;
   logic [TO_W-1:0]   to_cnt;
   logic [GW-1:0]     rr_ptr;
   logic [GW-1:0]     pick_idx;
   logic              pick_valid;
   logic [GW-1:0]     win_idx;
   logic              win_valid;
   logic [ADDR_W-1:0] win_addr;
   logic [GW-1:0]     rr_next;

   sdram_arb_pick #(
      .NUM_CH (NUM_CH),
      .GW     (GW)
   ) u_pick (
      .req   (ch_req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Winner (loader first), its physical address and the pointer value after serving it.
   always_comb begin
      win_valid = ch_req[0] | pick_valid;
      win_idx   = ch_req[0] ? '0 : pick_idx;
      win_addr  = ADDR_W'(region_addr(32'(CH_BASE[32'(win_idx)*ADDR_W +: ADDR_W]),
                                      32'(ch_addr[32'(win_idx)*CH_AW +: CH_AW]),
                                      CH_SIZE_LOG2[32'(win_idx)*5 +: 5]));
      rr_next   = (win_idx == GW'(NUM_CH - 1)) ? GW'(1) : win_idx + GW'(1);
   end

   assign busy = (state != StIdle);

   // Transaction FSM with all controller-facing and channel-facing outputs registered.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= StIdle;
         we_q        <= 1'b0;
         to_cnt      <= '0;
         rr_ptr      <= GW'(1);
         grant       <= '0;
         sdram_addr  <= '0;
         sdram_din   <= '0;
         sdram_rd    <= 1'b0;
         sdram_we    <= 1'b0;
         ch_ack      <= '0;
         ch_dout     <= '1;
         timeout_err <= 1'b0;
      end else begin
         sdram_rd <= 1'b0;
         sdram_we <= 1'b0;
         ch_ack   <= '0;
         case (state)
            StIdle: begin
               if (win_valid) begin
                  grant      <= win_idx;
                  we_q       <= ch_we[win_idx];
                  sdram_addr <= win_addr;
                  sdram_din  <= ch_din[32'(win_idx)*8 +: 8];
                  sdram_rd   <= ~ch_we[win_idx];
                  sdram_we   <= ch_we[win_idx];
                  // Loader grants leave the round-robin position untouched.
                  if (win_idx != '0) rr_ptr <= rr_next;
                  state <= StIssue;
               end
            end
            StIssue: begin
               to_cnt <= '0;
               state  <= StWait;
            end
            StWait: begin
               // Ready takes precedence over a timeout in the same cycle.
               if (sdram_ready) begin
                  if (!we_q) ch_dout[32'(grant)*8 +: 8] <= sdram_dout;
                  ch_ack[grant] <= 1'b1;
                  state         <= StAck;
               end else if (to_cnt == TO_W'(TIMEOUT)) begin
                  if (!we_q) ch_dout[32'(grant)*8 +: 8] <= 8'hFF;
                  timeout_err   <= 1'b1;
                  ch_ack[grant] <= 1'b1;
                  state         <= StAck;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            StAck: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_region_arbiter.sv
// Scoreboard bench for sdram_region_arbiter: stimulus pushes expected strobes and acks,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_sdram_region_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic [3:0]  ch_req  = '0;
   logic [3:0]  ch_we   = '0;
   logic [63:0] ch_addr = '0;
   logic [31:0] ch_din  = '0;
   logic [31:0] ch_dout;
   logic [3:0]  ch_ack;
   logic [22:0] sdram_addr;
   logic [7:0]  sdram_din;
   logic        sdram_rd;
   logic        sdram_we;
   logic [7:0]  sdram_dout  = '0;
   logic        sdram_ready = 1'b0;
   logic        busy;
   logic [1:0]  grant;
   logic        timeout_err;

   always #5 clk_sys = ~clk_sys;

   sdram_region_arbiter dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ch_req      (ch_req),
      .ch_we       (ch_we),
      .ch_addr     (ch_addr),
      .ch_din      (ch_din),
      .ch_dout     (ch_dout),
      .ch_ack      (ch_ack),
      .sdram_addr  (sdram_addr),
      .sdram_din   (sdram_din),
      .sdram_rd    (sdram_rd),
      .sdram_we    (sdram_we),
      .sdram_dout  (sdram_dout),
      .sdram_ready (sdram_ready),
      .busy        (busy),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [22:0] addr;
      logic        we;
      logic [7:0]  din;
      logic [1:0]  gnt;
      int          cyc;
   } strobe_t;

   typedef struct {
      logic [1:0] ch;
      logic       rd;
      logic [7:0] data;
      logic       err;
      int         cyc;
   } ack_t;

   strobe_t    sq[$];
   ack_t       aq[$];
   logic [7:0] model_dout [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

   task automatic exp_strobe(input logic [22:0] addr, input logic we, input logic [7:0] din,
                             input logic [1:0] gnt, input int c);
      strobe_t s;
      s.addr = addr; s.we = we; s.din = din; s.gnt = gnt; s.cyc = c;
      sq.push_back(s);
   endtask

   task automatic exp_ack(input logic [1:0] ch, input logic rd, input logic [7:0] data,
                          input logic err, input int c);
      ack_t a;
      a.ch = ch; a.rd = rd; a.data = data; a.err = err; a.cyc = c;
      aq.push_back(a);
   endtask

   // Monitor: compare every strobe and every ack against the head of its queue.
   always @(negedge clk_sys) begin
      strobe_t s;
      ack_t    a;
      if (!reset) begin
         if (sdram_rd || sdram_we) begin
            if (sq.size() == 0) chk("unexpected_strobe", {sdram_rd, sdram_we}, 2'b00);
            else begin
               s = sq.pop_front();
               chk("strobe_kind", {sdram_rd, sdram_we}, s.we ? 2'b01 : 2'b10);
               chk("strobe_addr", sdram_addr, s.addr);
               chk("strobe_grant", grant, s.gnt);
               chk("strobe_busy", busy, 1);
               if (s.we) chk("strobe_din", sdram_din, s.din);
               if (s.cyc >= 0) chk("strobe_cycle", cyc, s.cyc);
            end
         end
         if (ch_ack != 4'b0) begin
            if (aq.size() == 0) chk("unexpected_ack", ch_ack, 0);
            else begin
               a = aq.pop_front();
               if (a.rd) model_dout[a.ch] = a.data;
               chk("ack_vector", ch_ack, 64'(1) << a.ch);
               chk("ack_dout", ch_dout,
                   {model_dout[3], model_dout[2], model_dout[1], model_dout[0]});
               chk("ack_timeout_err", timeout_err, a.err);
               if (a.cyc >= 0) chk("ack_cycle", cyc, a.cyc);
            end
         end
      end
   end

   // SDRAM model: ready resp_lat cycles after a strobe (0 = never), data = ~addr[7:0].
   int         resp_lat = 2;
   int         resp_cd  = 0;
   logic [7:0] resp_data = '0;
   always @(posedge clk_sys) begin
      #1;
      sdram_ready = 1'b0;
      if (reset) resp_cd = 0;
      else begin
         if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
               sdram_ready = 1'b1;
               sdram_dout  = resp_data;
            end
         end
         if ((sdram_rd || sdram_we) && resp_lat > 0) begin
            resp_cd   = resp_lat;
            resp_data = ~sdram_addr[7:0];
         end
      end
   end

   // Requesters: hold ch_req while transactions remain, count one off per ack.
   int pend [4] = '{0, 0, 0, 0};
   always @(posedge clk_sys) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (ch_ack[i] && pend[i] > 0) pend[i]--;
         ch_req[i] = (pend[i] > 0);
      end
   end

   task automatic issue(input int ch, input logic we, input logic [15:0] addr,
                        input logic [7:0] din, input int n);
      ch_we[ch]            = we;
      ch_addr[ch*16 +: 16] = addr;
      ch_din[ch*8 +: 8]    = din;
      pend[ch]             = pend[ch] + n;
   endtask

   task automatic wait_done(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk_sys);
         done = (pend[0] + pend[1] + pend[2] + pend[3] == 0) && aq.size() == 0 &&
                sq.size() == 0;
      end
      chk("wait_done", done, 1);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic check_reset();
      chk("rst_ch_dout", ch_dout, 32'hFFFF_FFFF);
      chk("rst_ch_ack", ch_ack, 0);
      chk("rst_sdram_rd", sdram_rd, 0);
      chk("rst_sdram_we", sdram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_sdram_addr", sdram_addr, 0);
      chk("rst_sdram_din", sdram_din, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   c0;
      logic seen;

      repeat (3) @(negedge clk_sys);
      check_reset();
      reset = 1'b0;
      @(negedge clk_sys);

      // Single read on channel 2: base 0x04000 + 0x0123.
      resp_lat = 2;
      c0 = cyc + 1;
      exp_strobe(23'h004123, 1'b0, 8'h00, 2'd2, c0 + 1);
      exp_ack(2'd2, 1'b1, 8'hDC, 1'b0, c0 + 4);
      issue(2, 1'b0, 16'h0123, 8'h00, 1);
      wait_done(50);

      // Channels 0 and 3 together: 0 first, 3 sampled in the IDLE after its ACK.
      c0 = cyc + 1;
      exp_strobe(23'h000010, 1'b0, 8'h00, 2'd0, c0 + 1);
      exp_strobe(23'h01ABCD, 1'b0, 8'h00, 2'd3, c0 + 6);
      exp_ack(2'd0, 1'b1, 8'hEF, 1'b0, c0 + 4);
      exp_ack(2'd3, 1'b1, 8'h32, 1'b0, c0 + 9);
      issue(0, 1'b0, 16'h0010, 8'h00, 1);
      issue(3, 1'b0, 16'hABCD, 8'h00, 1);
      wait_done(60);

      // Channels 1, 2, 3 requesting together; channel 1 wants two transfers.
`ifdef SDRAM_ARB_RR_EN
      exp_strobe(23'h000001, 1'b0, 8'h00, 2'd1, -1);
      exp_strobe(23'h004002, 1'b0, 8'h00, 2'd2, -1);
      exp_strobe(23'h010003, 1'b0, 8'h00, 2'd3, -1);
      exp_strobe(23'h000001, 1'b0, 8'h00, 2'd1, -1);
      exp_ack(2'd1, 1'b1, 8'hFE, 1'b0, -1);
      exp_ack(2'd2, 1'b1, 8'hFD, 1'b0, -1);
      exp_ack(2'd3, 1'b1, 8'hFC, 1'b0, -1);
      exp_ack(2'd1, 1'b1, 8'hFE, 1'b0, -1);
`else
      exp_strobe(23'h000001, 1'b0, 8'h00, 2'd1, -1);
      exp_strobe(23'h000001, 1'b0, 8'h00, 2'd1, -1);
      exp_strobe(23'h004002, 1'b0, 8'h00, 2'd2, -1);
      exp_strobe(23'h010003, 1'b0, 8'h00, 2'd3, -1);
      exp_ack(2'd1, 1'b1, 8'hFE, 1'b0, -1);
      exp_ack(2'd1, 1'b1, 8'hFE, 1'b0, -1);
      exp_ack(2'd2, 1'b1, 8'hFD, 1'b0, -1);
      exp_ack(2'd3, 1'b1, 8'hFC, 1'b0, -1);
`endif
      issue(1, 1'b0, 16'h0001, 8'h00, 2);
      issue(2, 1'b0, 16'h0002, 8'h00, 1);
      issue(3, 1'b0, 16'h0003, 8'h00, 1);
      wait_done(100);

      // No ready: ack after 256 WAIT cycles, data 0xFF, sticky error.
      resp_lat = 0;
      c0 = cyc + 1;
      exp_strobe(23'h000100, 1'b0, 8'h00, 2'd1, c0 + 1);
      exp_ack(2'd1, 1'b1, 8'hFF, 1'b1, c0 + 258);
      issue(1, 1'b0, 16'h0100, 8'h00, 1);
      wait_done(400);
      repeat (5) @(negedge clk_sys);
      chk("timeout_err_sticky", timeout_err, 1);

      // Writes with out-of-region addresses get masked; ch_dout untouched.
      resp_lat = 1;
      exp_strobe(23'h007FFF, 1'b1, 8'h3C, 2'd0, -1);
      exp_strobe(23'h003FFF, 1'b1, 8'hA5, 2'd1, -1);
      exp_ack(2'd0, 1'b0, 8'h00, 1'b1, -1);
      exp_ack(2'd1, 1'b0, 8'h00, 1'b1, -1);
      issue(0, 1'b1, 16'hFFFF, 8'h3C, 1);
      issue(1, 1'b1, 16'hFFFF, 8'hA5, 1);
      wait_done(60);

      // Reset during WAIT aborts the read with no ack.
      resp_lat = 0;
      exp_strobe(23'h004200, 1'b0, 8'h00, 2'd2, -1);
      issue(2, 1'b0, 16'h0200, 8'h00, 1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_sys);
         seen = sdram_rd;
      end
      chk("abort_strobe_seen", seen, 1);
      repeat (2) @(negedge clk_sys);
      chk("abort_busy_in_wait", busy, 1);
      pend[2] = 0;
      reset   = 1'b1;
      @(negedge clk_sys);
      check_reset();
      reset = 1'b0;
      model_dout = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      repeat (10) @(negedge clk_sys);
      chk("abort_no_ack", ch_ack, 0);

      // Fresh read after the abort completes normally.
      resp_lat = 2;
      c0 = cyc + 1;
      exp_strobe(23'h004255, 1'b0, 8'h00, 2'd2, c0 + 1);
      exp_ack(2'd2, 1'b1, 8'hAA, 1'b0, c0 + 4);
      issue(2, 1'b0, 16'h0255, 8'h00, 1);
      wait_done(50);

      repeat (5) @(negedge clk_sys);
      chk("strobe_queue_drained", sq.size(), 0);
      chk("ack_queue_drained", aq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
